// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a valid/ready
// handshake on both sides. Storage is one output register plus one skid entry.
// Each entry holds a decoded result (immediate, format, tag).
// Optional feature macro: IMM_ILLEGAL_FLAG_EN. It adds the out_illegal flag and
// rejects words whose instr[1:0] is not 2'b11.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_FLAG_EN
    ,
    output logic             out_illegal
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_U   = 3'b011,
        FMT_J   = 3'b100,
        FMT_R   = 3'b101,
        FMT_BAD = 3'b111
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_t             fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_FLAG_EN
        logic             illegal;
`endif
    } res_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    occ_t        state_q, state_d;
    res_t        out_q, skid_q, dec;
    logic [31:0] imm32;
    logic        in_ready_q;
    logic        in_fire;
    logic        load_in, load_skid, skid_to_out;

    // Decode the incoming word into format and a 32-bit sign-extended immediate.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        imm32 = '0;
        dec   = '0;
        dec.fmt = FMT_BAD;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_REG, OP_REG32: dec.fmt = FMT_R;
            default:          dec.fmt = FMT_BAD;
        endcase
`ifdef IMM_ILLEGAL_FLAG_EN
        // Compressed or malformed words are rejected outright.
        if (in_instr[1:0] != 2'b11) begin
            dec.fmt = FMT_BAD;
            imm32   = '0;
        end
        dec.illegal = (dec.fmt == FMT_BAD);
`endif
        dec.tag = in_tag;
        // Every format's sign bit is instr[31], so extending the 32-bit value covers XLEN=64.
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_fire = in_valid & in_ready_q;

    // Occupancy next-state and the register-load controls it implies.
    always_comb begin
        state_d     = state_q;
        load_in     = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_in = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (out_ready) begin
                    if (in_fire) load_in = 1'b1;
                    else         state_d = EMPTY;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    skid_to_out = 1'b1;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides any same-cycle transfer: nothing is loaded.
        if (flush) begin
            state_d     = EMPTY;
            load_in     = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    // Occupancy state and the registered ready flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Output and skid data registers.
    always_ff @(posedge clk) begin
        // NOTE: data registers are reset here only because the outputs must read zero during reset.
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_in)          out_q <= dec;
            else if (skid_to_out) out_q <= skid_q;
            if (load_skid)        skid_q <= dec;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_imm   = out_q.imm;
    assign out_fmt   = out_q.fmt;
    assign out_tag   = out_q.tag;
`ifdef IMM_ILLEGAL_FLAG_EN
    assign out_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the
// same stimulus. A queue-based reference model checks both every cycle.
// Directed vectors then pin literal values.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready, out_valid;
    logic [31:0]      out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    logic             in_ready64, out_valid64;
    logic [63:0]      out_imm64;
    logic [2:0]       out_fmt64;
    logic [TAG_W-1:0] out_tag64;
`ifdef IMM_ILLEGAL_FLAG_EN
    logic             out_illegal, out_illegal64;
`endif

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_tag(out_tag)
`ifdef IMM_ILLEGAL_FLAG_EN
        , .out_illegal(out_illegal)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_tag(out_tag64)
`ifdef IMM_ILLEGAL_FLAG_EN
        , .out_illegal(out_illegal64)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [TAG_W-1:0] tag;
        logic        illegal;
    } exp_t;

    exp_t             q[$];
    logic [TAG_W-1:0] pop_log[$];
    logic             rst_at_edge = 1'b0;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: field value minus 2^width when the sign bit (instr[31]) is set.
    function automatic exp_t model(input logic [31:0] w, input logic [TAG_W-1:0] tag);
        exp_t e;
        longint v;
        e.tag = tag;
        e.illegal = 1'b0;
        v = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd0; v = longint'(w[31:20]) - (w[31] ? (longint'(1) << 12) : 0);
            end
            7'h23: begin
                e.fmt = 3'd1; v = longint'({w[31:25], w[11:7]}) - (w[31] ? (longint'(1) << 12) : 0);
            end
            7'h63: begin
                e.fmt = 3'd2;
                v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? (longint'(1) << 13) : 0);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd3; v = longint'(w[31:12]) * 4096 - (w[31] ? (longint'(1) << 32) : 0);
            end
            7'h6F: begin
                e.fmt = 3'd4;
                v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? (longint'(1) << 21) : 0);
            end
            7'h33, 7'h3B: e.fmt = 3'd5;
            default: begin e.fmt = 3'd7; e.illegal = 1'b1; end
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    always @(posedge clk) rst_at_edge <= rst_n;

    // Compare process: DUT state reflects the last edge; then advance the model for the next edge.
    always @(negedge clk) begin
        int sz;
        sz = q.size();
        if (!rst_at_edge) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_out_imm", 64'(out_imm), 64'd0);
            check("rst_out_fmt", 64'(out_fmt), 64'd0);
            check("rst_out_tag", 64'(out_tag), 64'd0);
            check("rst_out_imm64", out_imm64, 64'd0);
`ifdef IMM_ILLEGAL_FLAG_EN
            check("rst_out_illegal", 64'(out_illegal), 64'd0);
`endif
        end else begin
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            check("in_ready", 64'(in_ready), 64'(sz < 2));
            check("out_valid64", 64'(out_valid64), 64'(sz != 0));
            check("in_ready64", 64'(in_ready64), 64'(sz < 2));
            if (sz != 0) begin
                check("out_imm", 64'(out_imm), 64'(q[0].imm[31:0]));
                check("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
                check("out_tag", 64'(out_tag), 64'(q[0].tag));
                check("out_imm64", out_imm64, q[0].imm);
                check("out_fmt64", 64'(out_fmt64), 64'(q[0].fmt));
                check("out_tag64", 64'(out_tag64), 64'(q[0].tag));
`ifdef IMM_ILLEGAL_FLAG_EN
                check("out_illegal", 64'(out_illegal), 64'(q[0].illegal));
                check("out_illegal64", 64'(out_illegal64), 64'(q[0].illegal));
`endif
            end
        end
        if (!rst_n || flush) begin
            q.delete();
        end else if (rst_at_edge) begin
            if (out_ready && sz != 0) pop_log.push_back(q.pop_front().tag);
            if (in_valid && sz < 2) q.push_back(model(in_instr, in_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single accepted transfer with out_ready=1; result is visible after one edge.
    task automatic send(input logic [31:0] w, input logic [TAG_W-1:0] tag);
        in_valid  = 1'b1;
        in_instr  = w;
        in_tag    = tag;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    exp_t   pin;
    logic   saw_stall;
    logic   fire;
    logic [TAG_W-1:0] next_tag;
    logic [6:0] ops[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;

        // Pin the model itself against hand-computed values.
        pin = model(32'hFFF00093, 5'd0);
        check("model_addi_imm", pin.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        pin = model(32'hFE000EE3, 5'd0);
        check("model_beq_imm", pin.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        pin = model(32'h800002B7, 5'd0);
        check("model_lui_imm", pin.imm, 64'hFFFF_FFFF_8000_0000);
        check("model_lui_fmt", 64'(pin.fmt), 64'd3);

        repeat (3) step();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        step();
        check("release_ready", 64'(in_ready), 64'd1);
        check("release_valid", 64'(out_valid), 64'd0);

        // Directed immediates.
        send(32'hFFF00093, 5'd1);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        check("addi_fmt", 64'(out_fmt), 64'd0);
        send(32'h00112623, 5'd2);
        check("sw_imm", 64'(out_imm), 64'h0000_000C);
        check("sw_fmt", 64'(out_fmt), 64'd1);
        send(32'hFE000EE3, 5'd3);
        check("beq_m4_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("beq_fmt", 64'(out_fmt), 64'd2);
        // instr[7]=0 here, so imm[11]=0: -2052.
        send(32'hFE000E63, 5'd4);
        check("beq_e63_imm", 64'(out_imm), 64'hFFFF_F7FC);
        send(32'hFF9FF06F, 5'd5);
        check("jal_imm", 64'(out_imm), 64'hFFFF_FFF8);
        check("jal_fmt", 64'(out_fmt), 64'd4);
        send(32'h800002B7, 5'd6);
        check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui_fmt64", 64'(out_fmt64), 64'd3);
        check("lui_tag", 64'(out_tag), 64'd6);
        send(32'h00A08033, 5'd7);
        check("r_imm", 64'(out_imm), 64'd0);
        check("r_fmt", 64'(out_fmt), 64'd5);
        send(32'h0000007F, 5'd8);
        check("bad_fmt", 64'(out_fmt), 64'd7);
        check("bad_imm", 64'(out_imm), 64'd0);
`ifdef IMM_ILLEGAL_FLAG_EN
        check("bad_illegal", 64'(out_illegal), 64'd1);
        send(32'h00000013, 5'd9);
        check("nop_illegal", 64'(out_illegal), 64'd0);
        check("nop_fmt", 64'(out_fmt), 64'd0);
        check("nop_imm", 64'(out_imm), 64'd0);
        send(32'h00000010, 5'd10);
        check("rvc_illegal", 64'(out_illegal), 64'd1);
        check("rvc_fmt", 64'(out_fmt), 64'd7);
`endif
        step();

        // Stream tags 1..6, consumer stalled in cycles 2-4.
        pop_log.delete();
        saw_stall = 1'b0;
        next_tag  = 5'd1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            in_valid  = (next_tag <= 5'd6);
            in_instr  = 32'h00100093 + {next_tag, 20'd0};
            in_tag    = next_tag;
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (!in_ready) saw_stall = 1'b1;
            fire = in_valid && in_ready;
            step();
            if (fire) next_tag++;
        end
        in_valid = 1'b0;
        check("stream_stall_seen", 64'(saw_stall), 64'd1);
        check("stream_count", 64'(pop_log.size()), 64'd6);
        for (int i = 0; i < pop_log.size() && i < 6; i++)
            check("stream_order", 64'(pop_log[i]), 64'(i + 1));

        // Flush while FULL, with a same-cycle input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 5'd1; step();
        in_tag = 5'd2; step();
        check("full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_tag = 5'd9; step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        // Flush in ONE with an acceptable input: input must be dropped.
        in_valid = 1'b1; in_tag = 5'd3; step();
        flush = 1'b1; in_tag = 5'd10; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            check("flush_drop_valid", 64'(out_valid), 64'd0);
        end

        // Reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd17; step();
        in_tag = 5'd18; step();
        rst_n = 1'b0; in_valid = 1'b0; step();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_imm", 64'(out_imm), 64'd0);
        check("midrst_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1; step();

        // Randomised traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] w;
            int k;
            w = $urandom();
            k = $urandom_range(0, 13);
            if (k < 11) w[6:0] = ops[k];
            in_instr  = w;
            in_tag    = TAG_W'($urandom());
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
